// File: rtl/cordic_sched.sv
// cordic_sched: round-robin sharing of one pipelined CORDIC core with tagged, credit-controlled, in-order responses
// Ports: req_valid/req_ready/req_angle (per-requester request channel), core_angle/core_cos/core_sin (shared core),
// resp_valid/resp_ready/resp_id/resp_cos/resp_sin/resp_err (FWFT response FIFO head), busy (work in flight or queued).
module cordic_sched #(
  parameter int DATA_WIDTH = 8,
  parameter int NUM_REQ = 4,
  parameter int CORDIC_LAT = 8,
  parameter int RESP_DEPTH = 4,
  parameter logic signed [DATA_WIDTH-1:0] MAX_ANGLE = 8'sb01_100100,
  localparam int IW = $clog2(NUM_REQ),
  localparam int PW = RESP_DEPTH > 1 ? $clog2(RESP_DEPTH) : 1,
  localparam int CW = $clog2(RESP_DEPTH + 1)
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_REQ-1:0]            req_valid,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_angle,
  output logic [DATA_WIDTH-1:0]         core_angle,
  input  logic [DATA_WIDTH-1:0]         core_cos,
  input  logic [DATA_WIDTH-1:0]         core_sin,
  output logic                          resp_valid,
  input  logic                          resp_ready,
  output logic [IW-1:0]                 resp_id,
  output logic [DATA_WIDTH-1:0]         resp_cos,
  output logic [DATA_WIDTH-1:0]         resp_sin,
  output logic                          resp_err,
  output logic                          busy
);
  localparam int EW = IW + 1 + 2 * DATA_WIDTH;
  logic [IW-1:0] ptr_q, ptr_d, gnt;
  logic found, credit, hs, illegal, push, pop;
  logic signed [DATA_WIDTH-1:0] ang;
  logic [DATA_WIDTH-1:0] angle_q, angle_d;
  logic [CORDIC_LAT:0] tv_q, tv_d, te_q, te_d;
  logic [CORDIC_LAT:0][IW-1:0] tid_q, tid_d;
  logic [RESP_DEPTH-1:0][EW-1:0] mem_q, mem_d;
  logic [PW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [CW-1:0] cnt_q, cnt_d, out_q, out_d;
  // Scan downward so the lowest offset from the pointer is the last (winning) assignment.
  always_comb begin
    gnt = '0;
    found = 1'b0;
    for (int i = NUM_REQ - 1; i >= 0; i--)
      if (req_valid[(int'(ptr_q) + i) % NUM_REQ]) begin
        gnt = IW'((int'(ptr_q) + i) % NUM_REQ);
        found = 1'b1;
      end
  end
  always_comb begin
    // Credits count tags in flight plus queued results, so a push can never find the FIFO full.
    credit = !rst && out_q < CW'(RESP_DEPTH);
    hs = found && credit;
    req_ready = hs ? (NUM_REQ'(1) << gnt) : '0;
    ang = req_angle[gnt*DATA_WIDTH +: DATA_WIDTH];
    illegal = ang > MAX_ANGLE || ang < -MAX_ANGLE;
    push = tv_q[CORDIC_LAT];
    pop = resp_ready && cnt_q != '0;
    ptr_d = hs ? (gnt == IW'(NUM_REQ - 1) ? '0 : gnt + 1'b1) : ptr_q;
    angle_d = hs ? (illegal ? '0 : ang) : angle_q;
    tv_d = {tv_q[CORDIC_LAT-1:0], hs};
    te_d = {te_q[CORDIC_LAT-1:0], illegal};
    tid_d = {tid_q[CORDIC_LAT-1:0], gnt};
    mem_d = mem_q;
    if (push)
      mem_d[wr_q] = {tid_q[CORDIC_LAT], te_q[CORDIC_LAT],
                     core_cos & {DATA_WIDTH{~te_q[CORDIC_LAT]}},
                     core_sin & {DATA_WIDTH{~te_q[CORDIC_LAT]}}};
    wr_d = push ? (wr_q == PW'(RESP_DEPTH - 1) ? '0 : wr_q + 1'b1) : wr_q;
    rd_d = pop ? (rd_q == PW'(RESP_DEPTH - 1) ? '0 : rd_q + 1'b1) : rd_q;
    cnt_d = cnt_q + CW'(push) - CW'(pop);
    out_d = out_q + CW'(hs) - CW'(pop);
    resp_valid = cnt_q != '0;
    {resp_id, resp_err, resp_cos, resp_sin} = resp_valid ? mem_q[rd_q] : '0;
    core_angle = angle_q;
    busy = |tv_q || resp_valid;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q <= '0;
      angle_q <= '0;
      tv_q <= '0;
      te_q <= '0;
      tid_q <= '0;
      mem_q <= '0;
      wr_q <= '0;
      rd_q <= '0;
      cnt_q <= '0;
      out_q <= '0;
    end else begin
      ptr_q <= ptr_d;
      angle_q <= angle_d;
      tv_q <= tv_d;
      te_q <= te_d;
      tid_q <= tid_d;
      mem_q <= mem_d;
      wr_q <= wr_d;
      rd_q <= rd_d;
      cnt_q <= cnt_d;
      out_q <= out_d;
    end
  end
  fifo_no_overflow: assert property (@(posedge clk) disable iff (rst)
    !(push && !pop && cnt_q == CW'(RESP_DEPTH)));
endmodule

// File: tb/tb_cordic_sched.sv
// tb_cordic_sched: directed self-checking bench for cordic_sched with a behavioural CORDIC core model
module tb_cordic_sched;
  localparam int NR = 4, DW = 8, L = 8;
  logic clk = 1'b0, rst = 1'b1;
  logic [NR-1:0] req_valid = '0, req_ready;
  logic [NR*DW-1:0] req_angle = '0;
  logic [DW-1:0] core_angle, core_cos, core_sin, resp_cos, resp_sin;
  logic resp_valid, resp_ready = 1'b0, resp_err, busy;
  logic [1:0] resp_id;
  int checks = 0, errors = 0, cyc = 0, oh_bad = 0;
  always #5 clk = ~clk;
  cordic_sched #(.DATA_WIDTH(DW), .NUM_REQ(NR), .CORDIC_LAT(L), .RESP_DEPTH(4)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .req_angle(req_angle),
    .core_angle(core_angle), .core_cos(core_cos), .core_sin(core_sin),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_id(resp_id),
    .resp_cos(resp_cos), .resp_sin(resp_sin), .resp_err(resp_err), .busy(busy));
  logic [DW-1:0] cpipe [L];
  always @(posedge clk) begin
    cpipe[0] <= core_angle;
    for (int i = 1; i < L; i++) cpipe[i] <= cpipe[i-1];
  end
  function automatic logic [DW-1:0] fx(input real x);
    return DW'($rtoi(x * 64.0 + (x < 0.0 ? -0.5 : 0.5)));
  endfunction
  always_comb begin
    core_cos = fx($cos(real'($signed(cpipe[L-1])) / 64.0));
    core_sin = fx($sin(real'($signed(cpipe[L-1])) / 64.0));
  end
  typedef struct {int id; int err; int c; int s; int cyc;} rsp_t;
  typedef struct {int r; int a; int err; int c; int s;} vec_t;
  rsp_t rq[$];
  int gq[$];
  vec_t vec [11];
  int ecos [4] = '{58, 37, 62, 64};
  int esin [4] = '{27, 52, 14, 0};
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) if (!rst) begin
    if (resp_valid && resp_ready)
      rq.push_back('{int'(resp_id), int'(resp_err), int'($signed(resp_cos)), int'($signed(resp_sin)), cyc});
    if (req_ready != '0 && !$onehot(req_ready)) oh_bad <= oh_bad + 1;
    for (int i = 0; i < NR; i++) if (req_ready[i] && req_valid[i]) gq.push_back(i);
  end
  task automatic chk(input string n, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", n, act, exp);
    end
  endtask
  task automatic chk_tol(input string n, input int act, input int exp);
    checks++;
    if (act > exp + 2 || act < exp - 2) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d +-2", n, act, exp);
    end
  endtask
  function automatic int gat(input int i);
    return i < gq.size() ? gq[i] : -1;
  endfunction
  task automatic chk_rsp(input int i, input int id, input int err, input int c, input int s);
    if (i >= rq.size()) chk("rsp missing", rq.size(), i + 1);
    else begin
      chk($sformatf("rsp%0d id", i), rq[i].id, id);
      chk($sformatf("rsp%0d err", i), rq[i].err, err);
      chk_tol($sformatf("rsp%0d cos", i), rq[i].c, c);
      chk_tol($sformatf("rsp%0d sin", i), rq[i].s, s);
    end
  endtask
  task automatic chk_reset(input string n);
    chk({n, " req_ready"}, int'(req_ready), 0);
    chk({n, " core_angle"}, int'(core_angle), 0);
    chk({n, " resp_valid"}, int'(resp_valid), 0);
    chk({n, " resp_id"}, int'(resp_id), 0);
    chk({n, " resp_cos"}, int'(resp_cos), 0);
    chk({n, " resp_sin"}, int'(resp_sin), 0);
    chk({n, " resp_err"}, int'(resp_err), 0);
    chk({n, " busy"}, int'(busy), 0);
  endtask
  task automatic set_ang(input int a0, input int a1, input int a2, input int a3);
    req_angle = {DW'(a3), DW'(a2), DW'(a1), DW'(a0)};
  endtask
  task automatic run(input logic [NR-1:0] mask, input int n);
    int got = 0;
    req_valid = mask;
    for (int c = 0; c < 200 && got < n; c++) begin
      @(negedge clk);
      if (|(req_valid & req_ready)) got++;
      @(posedge clk);
      #1;
    end
    req_valid = '0;
    if (got < n) chk("run handshakes", got, n);
  endtask
  task automatic drain();
    int c = 0;
    while (busy && c < 100) begin
      @(negedge clk);
      c++;
    end
    chk("drain busy", int'(busy), 0);
    @(posedge clk);
    #1;
  endtask
  task automatic clear();
    rq.delete();
    gq.delete();
  endtask
  initial begin
    int n;
    bit seen;
    vec[0] = '{0, 14, 0, 62, 14};
    vec[1] = '{1, 28, 0, 58, 27};
    vec[2] = '{2, 61, 0, 37, 52};
    vec[3] = '{3, 0, 0, 64, 0};
    vec[4] = '{1, -28, 0, 58, -27};
    vec[5] = '{2, 100, 0, 1, 64};
    vec[6] = '{3, -100, 0, 1, -64};
    vec[7] = '{0, 101, 1, 0, 0};
    vec[8] = '{1, -101, 1, 0, 0};
    vec[9] = '{2, 112, 1, 0, 0};
    vec[10] = '{3, -112, 1, 0, 0};
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_reset("reset");
    @(posedge clk);
    #1 rst = 1'b0;
    resp_ready = 1'b1;
    for (int v = 0; v < 11; v++) begin
      req_angle = '0;
      req_angle[vec[v].r*DW +: DW] = DW'(vec[v].a);
      req_valid = '0;
      req_valid[vec[v].r] = 1'b1;
      seen = 0;
      for (int c = 0; c < 20 && !seen; c++) begin
        @(negedge clk);
        seen = req_ready[vec[v].r];
        if (!seen) begin
          @(posedge clk);
          #1;
        end
      end
      chk($sformatf("v%0d grant", v), int'(seen), 1);
      @(posedge clk);
      #1 req_valid = '0;
      n = 0;
      seen = 0;
      for (int c = 0; c < 40 && !seen; c++) begin
        @(posedge clk);
        n++;
        @(negedge clk);
        seen = resp_valid;
      end
      chk($sformatf("v%0d latency", v), n, L + 1);
      chk($sformatf("v%0d id", v), int'(resp_id), vec[v].r);
      chk($sformatf("v%0d err", v), int'(resp_err), vec[v].err);
      chk_tol($sformatf("v%0d cos", v), int'($signed(resp_cos)), vec[v].c);
      chk_tol($sformatf("v%0d sin", v), int'($signed(resp_sin)), vec[v].s);
      @(posedge clk);
      #1;
    end
    drain();
    clear();
    set_ang(28, 61, 14, 0);
    run('1, 8);
    drain();
    chk("rr grants", gq.size(), 8);
    for (int i = 0; i < 8; i++) chk($sformatf("rr grant%0d", i), gat(i), i % 4);
    chk("rr responses", rq.size(), 8);
    for (int i = 0; i < 8; i++) chk_rsp(i, i % 4, 0, ecos[i%4], esin[i%4]);
    clear();
    set_ang(14, 112, -112, 28);
    run('1, 4);
    drain();
    for (int i = 0; i < 4; i++) chk($sformatf("oor grant%0d", i), gat(i), i);
    chk("oor responses", rq.size(), 4);
    chk_rsp(0, 0, 0, 62, 14);
    chk_rsp(1, 1, 1, 0, 0);
    chk_rsp(2, 2, 1, 0, 0);
    chk_rsp(3, 3, 0, 58, 27);
    clear();
    set_ang(28, 61, 14, 0);
    resp_ready = 1'b0;
    req_valid = '1;
    repeat (30) @(posedge clk);
    #1;
    @(negedge clk);
    chk("bp handshakes", gq.size(), 4);
    chk("bp req_ready", int'(req_ready), 0);
    chk("bp head id", int'(resp_id), 0);
    chk_tol("bp head cos", int'($signed(resp_cos)), 58);
    chk("bp busy", int'(busy), 1);
    @(posedge clk);
    #1 resp_ready = 1'b1;
    @(posedge clk);
    #1 resp_ready = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    @(negedge clk);
    chk("bp one credit", gq.size(), 5);
    chk("bp fifth grant", gat(4), 0);
    req_valid = '0;
    resp_ready = 1'b1;
    drain();
    chk("bp responses", rq.size(), 5);
    for (int i = 0; i < 5; i++) chk_rsp(i, i % 4, 0, ecos[i%4], esin[i%4]);
    clear();
    resp_ready = 1'b0;
    run(4'b0110, 2);
    repeat (L + 3) @(posedge clk);
    #1;
    run(4'b0110, 2);
    for (int i = 0; i < 4; i++) chk($sformatf("pre-reset grant%0d", i), gat(i), 1 + i % 2);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk_reset("mid reset");
    for (int i = 0; i < L + 2; i++) begin
      @(negedge clk);
      chk($sformatf("stale valid %0d", i), int'(resp_valid), 0);
      chk($sformatf("stale busy %0d", i), int'(busy), 0);
    end
    @(posedge clk);
    #1 clear();
    resp_ready = 1'b1;
    run('1, 1);
    chk("post-reset grant", gat(0), 0);
    drain();
    chk("post-reset responses", rq.size(), 1);
    chk_rsp(0, 0, 0, 58, 27);
    clear();
    resp_ready = 1'b0;
    run('1, 3);
    repeat (L + 4) @(posedge clk);
    #1;
    run('1, 1);
    repeat (L) @(posedge clk);
    #1 resp_ready = 1'b1;
    drain();
    chk("pushpop responses", rq.size(), 4);
    for (int i = 0; i < 4; i++) chk_rsp(i, (i + 1) % 4, 0, ecos[(i+1)%4], esin[(i+1)%4]);
    for (int i = 1; i < 4 && i < rq.size(); i++) chk($sformatf("pushpop gap%0d", i), rq[i].cyc - rq[0].cyc, i);
    chk("onehot req_ready", oh_bad, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
endmodule

// File: doc/cordic_sched.md
Name: cordic_sched

Overview:
- Shares one pipelined `cordic` core (fixed latency, one angle per cycle) between NUM_REQ requesters using round-robin arbitration.
- Tags each issued angle, re-associates core results with their requester, and returns them in issue order through a response FIFO.
- Credit-based flow control guarantees no result is ever dropped when the consumer stalls.
- Screens out angles outside CORDIC convergence range and returns them flagged as errors.

Parameters:
- DATA_WIDTH, 8, angle/cos/sin width; signed Q1.(DATA_WIDTH-2): 1 sign, 1 integer, DATA_WIDTH-2 fraction bits.
- NUM_REQ, 4, number of requesters (≥2).
- CORDIC_LAT, 8, core latency in cycles: core_angle change to valid core_cos/core_sin.
- RESP_DEPTH, 4, response FIFO depth (≥1); also the total credit count.
- MAX_ANGLE, 8'sb01_100100, largest legal |angle| (1.5625 rad).

Ports:
- clk  in  1  clock
- rst  in  1  reset; synchronous, active-high
- req_valid  in  NUM_REQ  per-requester request valid
- req_ready  out  NUM_REQ  per-requester accept
- req_angle  in  NUM_REQ*DATA_WIDTH  packed angles; requester i in bits [i*DATA_WIDTH +: DATA_WIDTH]
- core_angle  out  DATA_WIDTH  angle driven to the cordic core
- core_cos  in  DATA_WIDTH  core cosine output
- core_sin  in  DATA_WIDTH  core sine output
- resp_valid  out  1  response FIFO not empty
- resp_ready  in  1  consumer pop
- resp_id  out  clog2(NUM_REQ)  requester index of the head response
- resp_cos  out  DATA_WIDTH  head cosine
- resp_sin  out  DATA_WIDTH  head sine
- resp_err  out  1  head request was out of range
- busy  out  1  any tag in flight or FIFO non-empty

Behaviour:
- Reset: req_ready=0, core_angle=0, resp_valid=0, resp_id/cos/sin/err=0, busy=0.
- Reset also: RR pointer=0, tag pipe cleared, FIFO emptied, outstanding=0.
- Reset mid-operation: all in-flight results are discarded; no response is emitted for them.
- Credits: outstanding = tags in flight + FIFO occupancy. A grant is allowed only when outstanding < RESP_DEPTH. A same-cycle pop grants no extra credit.
- Arbitration: grant goes to the first requester with req_valid=1, searching from the RR pointer upward with wrap.
  - req_ready is combinational and one-hot to the granted index, gated by credit.
  - At most one handshake per cycle. Handshake = req_valid & req_ready at an edge.
  - After a handshake by g, the pointer becomes (g+1) mod NUM_REQ.
  - The pointer is unchanged on idle cycles.
- Issue, at handshake edge k:
  - Legal angle (-MAX_ANGLE ≤ angle ≤ MAX_ANGLE, signed compare): core_angle registered to it.
  - Otherwise: core_angle registered to 0 and the tag err bit is set.
  - On cycles with no handshake, core_angle holds its value.
- Tag pipe: shift register of depth CORDIC_LAT+1 carrying {valid, id, err}.
  - When the tag exits (edge k+CORDIC_LAT+1), push {id, err, err?0:core_cos, err?0:core_sin} into the FIFO.
  - The FIFO is never full at push, guaranteed by credits. An assertion must flag overflow.
- Latency: the earliest resp_valid is the cycle after edge k+CORDIC_LAT+1, i.e. CORDIC_LAT+1 cycles after acceptance. Throughput is 1/cycle when resp_ready=1 and RESP_DEPTH ≥ CORDIC_LAT+2.
- FIFO: first-word-fall-through. resp_* are stable while resp_valid=1 and resp_ready=0.
  - Simultaneous push and pop: occupancy unchanged, order preserved.
  - Pop when empty: ignored.
- Ordering: responses are strictly in acceptance order, across all requesters.
- busy = |tag_valid or FIFO non-empty. It is registered/derived from state only, with no combinational path from inputs.
- No combinational path from resp_ready to req_ready.

Test Plan:
1. Single request, requester 0, angle 8'b00_001110 (0.21875), resp_ready=1 → resp_valid exactly CORDIC_LAT+1 cycles after the handshake. Expect resp_id=0, err=0, cos=62/64±2 LSB, sin=14/64±2 LSB.
2. All 4 requesters valid continuously, angles 8'b00_011100 / 00_111101 / 00_001110 / 0, RESP_DEPTH=16 → grants 0,1,2,3,0,… one per cycle. Responses in the same order with matching ids; sin(0.4375)≈27/64, cos(0.953)≈37/64 ±2 LSB.
3. Out of range: angle 8'sb01_110000 (1.75) and -1.75 → resp_err=1, cos=sin=0, and ordering is kept relative to legal requests issued around them.
4. Backpressure, RESP_DEPTH=4, resp_ready=0 → exactly 4 handshakes, then req_ready=0 indefinitely. Raising resp_ready releases one credit per pop, with no lost or duplicated responses and no FIFO overflow assertion.
5. Assert rst for 1 cycle with 3 tags in flight and 2 in the FIFO → next cycle all outputs are at reset values. No stale response appears within the following CORDIC_LAT+2 cycles. The next grant goes to requester 0.
6. Simultaneous push and pop at full occupancy, resp_ready=1 throughout → occupancy constant, resp data continuous and in order.
